// File: rtl/ulpb_tx_arbiter_pkg.sv
// Shared definitions for the ULPB TX arbiter: FSM state encoding and default bus widths.
package ulpb_tx_arbiter_pkg;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StNodeReq,
    StRel,
    StStream,
    StWaitResp,
    StResp
  } state_e;

endpackage

// File: rtl/ulpb_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
module ulpb_tx_arbiter_rr_pick #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_grant,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx,
  output logic              found
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Upper segment (above last_grant) has priority, then wrap to the lower segment.
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req[i] && (i > 32'(last_grant))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req[i] && (i <= 32'(last_grant))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/ulpb_tx_arbiter.sv
// Round-robin arbiter sharing one ulpb_node32 TX port among NUM_REQ requesters.
// Grants whole messages, relays 4-phase word handshakes and routes SUCC/FAIL to the owner.
module ulpb_tx_arbiter
  import ulpb_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PEND,
  input  logic [NUM_REQ-1:0]            REQ_REQ,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  output logic [NUM_REQ-1:0]            REQ_SUCC,
  output logic [NUM_REQ-1:0]            REQ_FAIL,
  input  logic [NUM_REQ-1:0]            REQ_RESP_ACK,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic [ADDR_WIDTH-1:0]         TX_ADDR,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  output logic                          TX_PEND,
  output logic                          TX_REQ,
  input  logic                          TX_ACK,
  input  logic                          TX_SUCC,
  input  logic                          TX_FAIL,
  output logic                          TX_RESP_ACK
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]        gidx_q, gidx_d, last_q, last_d;
  logic [NUM_REQ-1:0]     req_q;
  logic [NUM_REQ-1:0]     ack_q, ack_d, succ_q, succ_d, fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]  tx_addr_q, tx_addr_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_pend_q, tx_pend_d, tx_req_q, tx_req_d;
  logic                   tx_resp_ack_q, tx_resp_ack_d, resp_done_q, resp_done_d;
  logic                   to_resp, node_any, node_succ;
  logic [NUM_REQ-1:0]     pick_grant;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;
  logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Arbitration runs on a registered request copy, keeping requester inputs off the pick path.
  ulpb_tx_arbiter_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req        (req_q),
    .last_grant (last_q),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .found      (pick_valid)
  );

  // Simultaneous SUCC and FAIL is reported as FAIL.
  assign node_any  = TX_SUCC | TX_FAIL;
  assign node_succ = TX_SUCC & ~TX_FAIL;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    ack_d         = ack_q;
    succ_d        = succ_q;
    fail_d        = fail_q;
    tx_addr_d     = tx_addr_q;
    tx_data_d     = tx_data_q;
    tx_pend_d     = tx_pend_q;
    tx_req_d      = tx_req_q;
    tx_resp_ack_d = tx_resp_ack_q;
    resp_done_d   = resp_done_q;
    to_resp       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        tx_addr_d = addr_arr[gidx_q];
        tx_data_d = data_arr[gidx_q];
        tx_pend_d = REQ_PEND[gidx_q];
        tx_req_d  = 1'b1;
        state_d   = StNodeReq;
      end
      StNodeReq: begin
        if (TX_ACK) begin
          tx_req_d      = 1'b0;
          ack_d[gidx_q] = 1'b1;
          state_d       = StRel;
        end else if (TX_FAIL) begin
          tx_req_d = 1'b0;
          to_resp  = 1'b1;
        end
      end
      StRel: begin
        if (!REQ_REQ[gidx_q] && !TX_ACK) begin
          ack_d[gidx_q] = 1'b0;
          state_d       = tx_pend_q ? StStream : StWaitResp;
        end
      end
      StStream: begin
        if (TX_FAIL) begin
          to_resp = 1'b1;
        end else if (REQ_REQ[gidx_q]) begin
          state_d = StLoad;
        end
      end
      StWaitResp: begin
        if (node_any) to_resp = 1'b1;
      end
      StResp: begin
        succ_d[gidx_q] = node_succ;
        fail_d[gidx_q] = TX_FAIL;
        if (!node_any) begin
          tx_resp_ack_d = 1'b0;
        end else if (REQ_RESP_ACK[gidx_q]) begin
          tx_resp_ack_d = 1'b1;
          resp_done_d   = 1'b1;
        end
        if (resp_done_q && !node_any && !REQ_RESP_ACK[gidx_q]) begin
          state_d     = StIdle;
          grant_d     = '0;
          last_d      = gidx_q;
          resp_done_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (to_resp) begin
      succ_d[gidx_q] = node_succ;
      fail_d[gidx_q] = TX_FAIL;
      state_d        = StResp;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      gidx_q        <= '0;
      last_q        <= IdxW'(NUM_REQ - 1);
      req_q         <= '0;
      ack_q         <= '0;
      succ_q        <= '0;
      fail_q        <= '0;
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      tx_pend_q     <= 1'b0;
      tx_req_q      <= 1'b0;
      tx_resp_ack_q <= 1'b0;
      resp_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      last_q        <= last_d;
      req_q         <= REQ_REQ;
      ack_q         <= ack_d;
      succ_q        <= succ_d;
      fail_q        <= fail_d;
      tx_addr_q     <= tx_addr_d;
      tx_data_q     <= tx_data_d;
      tx_pend_q     <= tx_pend_d;
      tx_req_q      <= tx_req_d;
      tx_resp_ack_q <= tx_resp_ack_d;
      resp_done_q   <= resp_done_d;
    end
  end

  assign REQ_ACK     = ack_q;
  assign REQ_SUCC    = succ_q;
  assign REQ_FAIL    = fail_q;
  assign GRANT       = grant_q;
  assign TX_ADDR     = tx_addr_q;
  assign TX_DATA     = tx_data_q;
  assign TX_PEND     = tx_pend_q;
  assign TX_REQ      = tx_req_q;
  assign TX_RESP_ACK = tx_resp_ack_q;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Bench for ulpb_tx_arbiter: behavioural node model, requester tasks and a queue scoreboard.
module tb_ulpb_tx_arbiter;

  logic        clk, rst;
  logic [23:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_pend, req_req, req_ack, req_succ, req_fail, req_resp_ack, grant;
  logic [7:0]  tx_addr;
  logic [31:0] tx_data;
  logic        tx_pend, tx_req, tx_ack, tx_succ, tx_fail, tx_resp_ack;
  logic        node_stall;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [2:0]  grant;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        pend;
  } word_t;

  typedef struct packed {
    logic [2:0] grant;
    logic [2:0] succ;
    logic [2:0] fail;
  } resp_t;

  word_t wq[$];
  resp_t rq[$];

  ulpb_tx_arbiter #(
    .NUM_REQ    (3),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .REQ_ADDR     (req_addr),
    .REQ_DATA     (req_data),
    .REQ_PEND     (req_pend),
    .REQ_REQ      (req_req),
    .REQ_ACK      (req_ack),
    .REQ_SUCC     (req_succ),
    .REQ_FAIL     (req_fail),
    .REQ_RESP_ACK (req_resp_ack),
    .GRANT        (grant),
    .TX_ADDR      (tx_addr),
    .TX_DATA      (tx_data),
    .TX_PEND      (tx_pend),
    .TX_REQ       (tx_req),
    .TX_ACK       (tx_ack),
    .TX_SUCC      (tx_succ),
    .TX_FAIL      (tx_fail),
    .TX_RESP_ACK  (tx_resp_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Node model: nodes ab/cd/ef exist, anything else FAILs; stream gaps over 20 cycles underflow.
  typedef enum logic [2:0] {NIdle, NAckDly, NAckHold, NStreamWait, NRespDly, NResp, NRespEnd} node_e;
  node_e n_st;
  int    n_cnt;
  logic  n_pend, n_fail;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      n_st <= NIdle; n_cnt <= 0; n_pend <= 1'b0; n_fail <= 1'b0;
      tx_ack <= 1'b0; tx_succ <= 1'b0; tx_fail <= 1'b0;
    end else begin
      case (n_st)
        NIdle: if (tx_req && !node_stall) begin
          n_cnt <= 1;
          if (tx_addr == 8'hab || tx_addr == 8'hcd || tx_addr == 8'hef) begin
            n_fail <= 1'b0; n_st <= NAckDly;
          end else begin
            n_fail <= 1'b1; n_st <= NRespDly;
          end
        end
        NAckDly: if (n_cnt == 0) begin
          tx_ack <= 1'b1; n_pend <= tx_pend; n_st <= NAckHold;
        end else n_cnt <= n_cnt - 1;
        NAckHold: if (!tx_req) begin
          tx_ack <= 1'b0;
          n_cnt  <= n_pend ? 20 : 2;
          n_st   <= n_pend ? NStreamWait : NRespDly;
        end
        NStreamWait: if (tx_req) begin
          n_cnt <= 1; n_st <= NAckDly;
        end else if (n_cnt == 0) begin
          n_fail <= 1'b1; n_st <= NRespDly;
        end else n_cnt <= n_cnt - 1;
        NRespDly: if (n_cnt == 0) begin
          tx_succ <= !n_fail; tx_fail <= n_fail; n_st <= NResp;
        end else n_cnt <= n_cnt - 1;
        NResp: if (tx_resp_ack) begin
          tx_succ <= 1'b0; tx_fail <= 1'b0; n_st <= NRespEnd;
        end
        NRespEnd: if (!tx_resp_ack) n_st <= NIdle;
        default: n_st <= NIdle;
      endcase
    end
  end

  // Monitor: a word is checked when the node first acks it, a response when SUCC/FAIL rises.
  initial begin
    logic  ack_prev, rsp_prev, rsp_now;
    word_t w;
    resp_t r;
    ack_prev = 1'b0;
    rsp_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_ack && !ack_prev) begin
        if (wq.size() == 0) begin
          n_checks++;
          $display("FAIL word_unexpected: got grant %b data %h, none queued", grant, tx_data);
        end else begin
          w = wq.pop_front();
          check("word", {grant, tx_addr, tx_data, tx_pend}, 64'(w));
        end
      end
      rsp_now = (|req_succ) | (|req_fail);
      if (rsp_now && !rsp_prev) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL resp_unexpected: got succ %b fail %b, none queued", req_succ, req_fail);
        end else begin
          r = rq.pop_front();
          check("resp", {grant, req_succ, req_fail}, 64'(r));
        end
      end
      ack_prev = tx_ack;
      rsp_prev = rsp_now;
    end
  end

  task automatic exp_word(input int r, input logic [7:0] a, input logic [31:0] d, input logic p);
    word_t w;
    w.grant = 3'b001 << r; w.addr = a; w.data = d; w.pend = p;
    wq.push_back(w);
  endtask

  task automatic exp_resp(input int r, input logic ok);
    resp_t x;
    x.grant = 3'b001 << r;
    x.succ  = ok ? (3'b001 << r) : 3'b000;
    x.fail  = ok ? 3'b000 : (3'b001 << r);
    rq.push_back(x);
  endtask

  task automatic exp_msg(input int r, input logic [7:0] a, input logic [31:0] base, input int n);
    for (int w = 0; w < n; w++) exp_word(r, a, base + 32'(w), (w < n - 1));
    exp_resp(r, 1'b1);
  endtask

  // Requester: sends nsend of nwords (stalls if nsend < nwords), then completes the response.
  task automatic send_msg(input int r, input logic [7:0] a, input logic [31:0] base,
                          input int nwords, input int nsend, input int lat_first,
                          input int lat_rest);
    int   n, lat;
    logic got_fail;
    got_fail = 1'b0;
    for (int w = 0; w < nsend && !got_fail; w++) begin
      @(negedge clk);
      req_addr[r*8 +: 8]  = a;
      req_data[r*32 +: 32] = base + 32'(w);
      req_pend[r]         = (w < nwords - 1);
      req_req[r]          = 1'b1;
      lat = (w == 0) ? lat_first : lat_rest;
      if (lat != 0) begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!tx_req && n < 20);
        check($sformatf("latency_r%0d_w%0d", r, w), 64'(n), 64'(lat));
      end
      n = 0;
      while (!req_ack[r] && !req_fail[r] && n < 1000) begin @(posedge clk); #1; n++; end
      check($sformatf("ack_r%0d_w%0d", r, w), 64'(req_ack[r] | req_fail[r]), 64'd1);
      got_fail = req_fail[r];
      @(negedge clk);
      req_req[r] = 1'b0;
      if (!got_fail) begin
        n = 0;
        while (req_ack[r] && n < 50) begin @(posedge clk); #1; n++; end
        check($sformatf("ack_release_r%0d", r), 64'(req_ack[r]), 64'd0);
      end
    end
    n = 0;
    while (!req_succ[r] && !req_fail[r] && n < 1000) begin @(posedge clk); #1; n++; end
    check($sformatf("resp_seen_r%0d", r), 64'(req_succ[r] | req_fail[r]), 64'd1);
    @(negedge clk);
    req_resp_ack[r] = 1'b1;
    n = 0;
    while ((req_succ[r] || req_fail[r]) && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("resp_clear_r%0d", r), 64'(req_succ[r] | req_fail[r]), 64'd0);
    @(negedge clk);
    req_resp_ack[r] = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req_ack, req_succ, req_fail, grant, tx_addr, tx_data, tx_pend, tx_req, tx_resp_ack});
  endfunction

  initial begin
    int n;
    rst = 1'b1; node_stall = 1'b0;
    req_addr = '0; req_data = '0; req_pend = '0; req_req = '0; req_resp_ack = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;

    // Single word from R0; IDLE latency 3
    exp_msg(0, 8'hcd, 32'h12345678, 1);
    send_msg(0, 8'hcd, 32'h12345678, 1, 1, 3, 0);
    @(posedge clk); #1;
    check("grant_idle_after_msg", 64'(grant), 64'd0);

    // Simultaneous requests from fresh reset: two rounds 0,1,2
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < 3; r++) exp_msg(r, 8'hcd, 32'h2000_0000 + 32'(round * 16 + r), 1);
      fork
        send_msg(0, 8'hcd, 32'h2000_0000 + 32'(round * 16), 1, 1, 0, 0);
        send_msg(1, 8'hcd, 32'h2000_0001 + 32'(round * 16), 1, 1, 0, 0);
        send_msg(2, 8'hcd, 32'h2000_0002 + 32'(round * 16), 1, 1, 0, 0);
      join
    end

    // R1 streams 8 words while R2 waits; STREAM latency 2
    exp_msg(1, 8'hcd, 32'h3000_0000, 8);
    exp_msg(2, 8'hcd, 32'h3100_0000, 1);
    fork
      send_msg(1, 8'hcd, 32'h3000_0000, 8, 8, 3, 2);
      send_msg(2, 8'hcd, 32'h3100_0000, 1, 1, 0, 0);
    join

    // R0 stalls mid-stream -> underflow FAIL; R1 served next
    exp_word(0, 8'hcd, 32'h4000_0000, 1'b1);
    exp_resp(0, 1'b0);
    exp_msg(1, 8'hcd, 32'h4100_0000, 1);
    fork
      send_msg(0, 8'hcd, 32'h4000_0000, 2, 1, 0, 0);
      send_msg(1, 8'hcd, 32'h4100_0000, 1, 1, 0, 0);
    join

    // Unknown address from R2
    exp_resp(2, 1'b0);
    send_msg(2, 8'hff, 32'h5000_0000, 1, 1, 0, 0);

    // R0 served last so a surviving last_grant would favour R1 afterwards
    exp_msg(0, 8'hcd, 32'h6000_0000, 1);
    send_msg(0, 8'hcd, 32'h6000_0000, 1, 1, 0, 0);

    // Reset while R1 sits in NODE_REQ
    node_stall = 1'b1;
    @(negedge clk);
    req_addr[15:8] = 8'hcd; req_data[63:32] = 32'h6100_0000; req_pend[1] = 1'b0;
    req_req[1] = 1'b1;
    n = 0;
    while (!tx_req && n < 20) begin @(posedge clk); #1; n++; end
    check("node_req_before_reset", 64'({tx_req, grant}), 64'({1'b1, 3'b010}));
    @(negedge clk);
    rst = 1'b1;
    req_req[1] = 1'b0;
    #1;
    check("reset_mid_op_outputs", all_outs(), 64'd0);
    node_stall = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_msg(0, 8'hcd, 32'h6200_0000, 1);
    exp_msg(1, 8'hcd, 32'h6300_0000, 1);
    fork
      send_msg(0, 8'hcd, 32'h6200_0000, 1, 1, 3, 0);
      send_msg(1, 8'hcd, 32'h6300_0000, 1, 1, 0, 0);
    join

    repeat (3) @(posedge clk);
    #1;
    check("words_drained", 64'(wq.size()), 64'd0);
    check("resps_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
